// File: rtl/bubble_pkg.sv
// Shared types and sizing for the bubble memory access sequencer.
package bubble_pkg;

  localparam int LOOP_LENGTH_DEF = 2048;
  localparam int PAGE_BITS_DEF   = 512;
  localparam int POS_W           = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_REPLICATE,
    ST_READ,
    ST_STOP
  } seq_state_t;

  // Position index advances one step, wrapping at the end of the minor loop.
  function automatic logic [POS_W-1:0] pos_next(input logic [POS_W-1:0] pos,
                                                input int loop_len);
    return (pos == POS_W'(loop_len - 1)) ? '0 : pos + 1'b1;
  endfunction

endpackage

// File: rtl/bubble_access_sequencer_if.sv
// Host request, timing-generator and bubble-control signals of the access sequencer.
interface bubble_access_sequencer_if;
  import bubble_pkg::*;

  logic             start;
  logic             abort;
  logic [POS_W-1:0] target_page;
  logic             bootloop_mode;
  logic             position_change;
  logic             bubble_data_out_clock;
  logic             bubble_data_in;
  logic             coil_enable;
  logic             bubble_shift_enable;
  logic             replicator_enable;
  logic             bootloop_enable;
  logic             busy;
  logic [7:0]       data_byte;
  logic             data_valid;
  logic [POS_W-1:0] current_position;

  modport master (
    output start, abort, target_page, bootloop_mode,
    output position_change, bubble_data_out_clock, bubble_data_in, coil_enable,
    input  bubble_shift_enable, replicator_enable, bootloop_enable, busy,
    input  data_byte, data_valid, current_position
  );

  modport slave (
    input  start, abort, target_page, bootloop_mode,
    input  position_change, bubble_data_out_clock, bubble_data_in, coil_enable,
    output bubble_shift_enable, replicator_enable, bootloop_enable, busy,
    output data_byte, data_valid, current_position
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for timing-generator inputs; optionally emits a one-cycle
// pulse on the rising edge of the synchronized level instead of the level itself.
module sync_edge_detect #(
  parameter bit EDGE_OUT = 1'b1
) (
  input  logic master_clock,
  input  logic master_reset,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_q;

  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) sync_q <= '0;
    else              sync_q <= {sync_q[0], din};
  end

  generate
    if (EDGE_OUT) begin : g_edge
      logic prev_q;
      always_ff @(posedge master_clock or posedge master_reset) begin
        if (master_reset) prev_q <= 1'b0;
        else              prev_q <= sync_q[1];
      end
      assign dout = sync_q[1] & ~prev_q;
    end else begin : g_level
      assign dout = sync_q[1];
    end
  endgenerate

endmodule

// File: rtl/bubble_access_sequencer.sv
// Sequences a bubble memory page read: seek to position, replicate, deserialise, stop.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start; bubble controls released
// SEEK      | shifting until the tracked position reaches the target
// REPLICATE | replicator active for one position period
// READ      | shifting detector bits into bytes until a page is read
// STOP      | controls released, waiting for the coils to stop
module bubble_access_sequencer
  import bubble_pkg::*;
#(
  parameter int LOOP_LENGTH = LOOP_LENGTH_DEF,
  parameter int PAGE_BITS   = PAGE_BITS_DEF
) (
  input  logic                      master_clock,
  input  logic                      master_reset,
  bubble_access_sequencer_if.slave  bus
);

  localparam int              CNT_W    = $clog2(PAGE_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAGE_BITS - 1);

  logic pos_rise, dclk_rise, din_sync, coil_sync;

  sync_edge_detect #(.EDGE_OUT(1'b1)) u_sync_pos (
    .master_clock(master_clock), .master_reset(master_reset),
    .din(bus.position_change), .dout(pos_rise));
  sync_edge_detect #(.EDGE_OUT(1'b1)) u_sync_dclk (
    .master_clock(master_clock), .master_reset(master_reset),
    .din(bus.bubble_data_out_clock), .dout(dclk_rise));
  sync_edge_detect #(.EDGE_OUT(1'b0)) u_sync_din (
    .master_clock(master_clock), .master_reset(master_reset),
    .din(bus.bubble_data_in), .dout(din_sync));
  sync_edge_detect #(.EDGE_OUT(1'b0)) u_sync_coil (
    .master_clock(master_clock), .master_reset(master_reset),
    .din(bus.coil_enable), .dout(coil_sync));

  seq_state_t       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_inc, target_q;
  logic             boot_q;
  logic [7:0]       shreg_q, data_byte_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             byte_done_q, data_valid_q;
  logic             load_req, enter_read, capture;

  assign pos_inc = pos_next(pos_q, LOOP_LENGTH);

  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_req   = 1'b0;
    enter_read = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          load_req = 1'b1;
          state_d  = (pos_q == bus.target_page) ? ST_REPLICATE : ST_SEEK;
        end
      end
      ST_SEEK: begin
        if (bus.abort)                              state_d = ST_STOP;
        else if (pos_rise && pos_inc == target_q)   state_d = ST_REPLICATE;
      end
      ST_REPLICATE: begin
        if (bus.abort) state_d = ST_STOP;
        else if (pos_rise) begin
          state_d    = ST_READ;
          enter_read = 1'b1;
        end
      end
      ST_READ: begin
        if (bus.abort) state_d = ST_STOP;
        else if (dclk_rise) begin
          capture = 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (coil_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte completion is flagged at the capturing edge and published one cycle later,
  // so an abort arriving after the eighth bit cannot cancel an already complete byte.
  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) begin
      pos_q        <= '0;
      target_q     <= '0;
      boot_q       <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      byte_done_q  <= 1'b0;
      data_byte_q  <= '0;
      data_valid_q <= 1'b0;
    end else begin
      byte_done_q  <= 1'b0;
      data_valid_q <= 1'b0;
      if (pos_rise) pos_q <= pos_inc;
      if (load_req) begin
        target_q <= bus.target_page;
        boot_q   <= bus.bootloop_mode;
      end
      if (enter_read) begin
        shreg_q   <= '0;
        bit_cnt_q <= '0;
      end else if (capture) begin
        shreg_q     <= {shreg_q[6:0], din_sync};
        bit_cnt_q   <= bit_cnt_q + 1'b1;
        byte_done_q <= (bit_cnt_q[2:0] == 3'd7);
      end
      if (byte_done_q) begin
        data_byte_q  <= shreg_q;
        data_valid_q <= 1'b1;
      end
    end
  end

  assign bus.busy                = (state_q != ST_IDLE);
  assign bus.bubble_shift_enable = !(state_q == ST_SEEK || state_q == ST_REPLICATE ||
                                     state_q == ST_READ);
  assign bus.replicator_enable   = (state_q != ST_REPLICATE);
  assign bus.bootloop_enable     = boot_q && (state_q != ST_IDLE);
  assign bus.data_byte           = data_byte_q;
  assign bus.data_valid          = data_valid_q;
  assign bus.current_position    = pos_q;

endmodule

// File: doc/bubble_access_sequencer.md
BUBBLE_ACCESS_SEQUENCER -- requirements
Module: bubble_access_sequencer

Interface
REQ-001 Parameter LOOP_LENGTH, default 2048, number of bubble positions per minor loop; position index wraps LOOP_LENGTH-1 -> 0.
REQ-002 Parameter PAGE_BITS, default 512, bits read per page access; multiple of 8.
REQ-003 master_clock  in  1  48 MHz system clock; all logic on its rising edge.
REQ-004 master_reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request; accepted only in IDLE.
REQ-006 abort  in  1  level; forces an orderly stop from any active state.
REQ-007 target_page  in  11  position index to read; sampled on accepted start.
REQ-008 bootloop_mode  in  1  1 = bootloop/program page access; sampled on accepted start.
REQ-009 position_change  in  1  active-high pulse per bubble position step, from the timing generator.
REQ-010 bubble_data_out_clock  in  1  bit clock from the timing generator; data is valid on its rising edge.
REQ-011 bubble_data_in  in  1  serial detector bit.
REQ-012 coil_enable  in  1  active-low coil-running indication from the timing generator.
REQ-013 bubble_shift_enable  out  1  active-low shift request; reset 1.
REQ-014 replicator_enable  out  1  active-low replicate request; reset 1.
REQ-015 bootloop_enable  out  1  active-high page select; reset 0.
REQ-016 busy  out  1  high in every state except IDLE; reset 0.
REQ-017 data_byte  out  8  deserialised byte, MSB first; reset 0x00.
REQ-018 data_valid  out  1  one-cycle strobe with each new data_byte; reset 0.
REQ-019 current_position  out  11  tracked position index; reset 0.

Function
REQ-020 position_change, bubble_data_out_clock, bubble_data_in and coil_enable SHALL pass through a 2-FF synchronizer; rising edges are detected on the synchronized signal, so each edge acts 3 cycles after the input edge.
REQ-021 One position_change pulse SHALL produce exactly one increment, however many cycles the pulse lasts.
REQ-022 current_position SHALL increment modulo LOOP_LENGTH on each detected position_change edge in any state.
REQ-023 States: IDLE, SEEK, REPLICATE, READ, STOP.
REQ-024 IDLE: start -> latch target_page and bootloop_mode; go to SEEK, or to REPLICATE if current_position == target_page.
REQ-025 SEEK: bubble_shift_enable=0; when the increment makes current_position equal target_page -> REPLICATE.
REQ-026 REPLICATE: bubble_shift_enable=0, replicator_enable=0 until the next position_change edge; then replicator_enable=1 -> READ.
REQ-027 READ: bubble_shift_enable=0; sample bubble_data_in on each bubble_data_out_clock edge into an 8-bit shift register, MSB first.
REQ-028 Every 8th bit SHALL load data_byte and pulse data_valid 1 cycle after the edge that captures that bit; after PAGE_BITS bits -> STOP.
REQ-029 The bit counter SHALL be log2(PAGE_BITS)+1 bits wide and SHALL clear on entry to READ.
REQ-030 STOP: bubble_shift_enable=1, replicator_enable=1; wait for synchronized coil_enable=1 -> IDLE.
REQ-031 bootloop_enable SHALL equal the latched bootloop_mode from SEEK entry until STOP exits, and 0 otherwise.
REQ-032 abort in SEEK, REPLICATE or READ -> STOP on the next cycle; a partial byte is discarded and data_valid does not pulse.
REQ-033 start while busy SHALL be ignored; start and abort in the same IDLE cycle -> remain IDLE.
REQ-034 A data clock edge in SEEK or REPLICATE SHALL be ignored.
REQ-035 Wrap: target 0 reached from 2047 with a single increment.

Reset
REQ-036 master_reset SHALL force IDLE, all outputs to their reset values, clear the synchronizers, shift register and counters, and set current_position to 0, asynchronously.
REQ-037 Reset mid-operation SHALL deassert the bubble controls immediately, with no STOP handshake.

Structure
REQ-038 Package bubble_pkg SHALL hold the state enumeration, LOOP_LENGTH default and position-index width.
REQ-039 The synchronizer and rising-edge detector SHALL be one sub-module, sync_edge_detect, instantiated once per input.

Verification
REQ-040 Reset, then start target=5, current=0 -> SEEK; after 5 position pulses -> REPLICATE; replicator_enable low for exactly one position period.
REQ-041 current=2040, target=3 -> SEEK through wrap; REPLICATE entered after exactly 11 pulses.
REQ-042 READ with pattern 0xA5 repeated, PAGE_BITS=512 -> 64 data_valid strobes, each data_byte=0xA5, then STOP; IDLE only after coil_enable=1.
REQ-043 abort after 13 bits in READ -> exactly 1 data_valid strobe, STOP next cycle, bubble_shift_enable=1.
REQ-044 bootloop_mode=1 start -> bootloop_enable=1 from SEEK until STOP exits; start during READ is ignored.
REQ-045 master_reset asserted mid-SEEK -> all outputs at reset values with no clock edge; current_position=0.
